// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic-light controller: one-hot state codes and default timings.
// bin_to_bcd exists only when TRAFFIC_TIMER_BCD_EN is defined.
package traffic_pkg;

    typedef enum logic [3:0] {
        S0 = 4'b0001,   // NS green
        S1 = 4'b0010,   // NS yellow
        S2 = 4'b0100,   // EW green
        S3 = 4'b1000    // EW yellow
    } state_t;

    localparam int DEF_TICK_DIV    = 50_000_000;
    localparam int DEF_CNT_W       = 8;
    localparam int DEF_NS_GRN_TIME = 30;
    localparam int DEF_EW_GRN_TIME = 20;
    localparam int DEF_YEL_TIME    = 3;

`ifdef TRAFFIC_TIMER_BCD_EN
    // Two-digit display: anything above 99 shows 99.
    function automatic logic [7:0] bin_to_bcd(input int unsigned v);
        logic [3:0] tens;
        logic [3:0] units;
        if (v > 99) begin
            return 8'h99;
        end
        tens  = 4'(v / 10);
        units = 4'(v % 10);
        return {tens, units};
    endfunction
`endif

endpackage

// File: rtl/traffic_down_cnt.sv
// Loadable down-counter that stops at zero. Done is decoded from the count register.
module traffic_down_cnt #(
    parameter int               CNT_W   = 8,
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Load,
    input  logic             Tick,
    input  logic [CNT_W-1:0] Load_val,
    output logic [CNT_W-1:0] Count,
    output logic             Done
);

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;

    // A load takes priority over a tick arriving in the same cycle.
    always_comb begin
        count_next = count_reg;
        if (Load) begin
            count_next = Load_val;
        end else if (Tick && (count_reg != '0)) begin
            count_next = count_reg - CNT_W'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            count_reg <= RST_VAL;
        end else begin
            count_reg <= count_next;
        end
    end

    assign Count = count_reg;
    assign Done  = (count_reg == '0);

endmodule

// File: rtl/traffic_timer.sv
// Phase timer for the traffic-light FSM: shared tick prescaler, load table, NS/EW counters.
// Define TRAFFIC_TIMER_BCD_EN to add registered BCD countdown outputs Bcd_NS/Bcd_EW.
module traffic_timer
    import traffic_pkg::*;
#(
    parameter int TICK_DIV    = DEF_TICK_DIV,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int NS_GRN_TIME = DEF_NS_GRN_TIME,
    parameter int EW_GRN_TIME = DEF_EW_GRN_TIME,
    parameter int YEL_TIME    = DEF_YEL_TIME
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Sload_NS,
    input  logic             Sload_EW,
    input  logic [3:0]       State_cnt,
    output logic             Done_NS,
    output logic             Done_EW,
    output logic [CNT_W-1:0] Count_NS,
    output logic [CNT_W-1:0] Count_EW,
    output logic             Tick
`ifdef TRAFFIC_TIMER_BCD_EN
    ,
    output logic [7:0]       Bcd_NS,
    output logic [7:0]       Bcd_EW
`endif
);

    localparam int               PRE_W    = $clog2(TICK_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] NS_GRN   = CNT_W'(NS_GRN_TIME);
    localparam logic [CNT_W-1:0] EW_GRN   = CNT_W'(EW_GRN_TIME);
    localparam logic [CNT_W-1:0] YEL      = CNT_W'(YEL_TIME);

    logic [PRE_W-1:0] pre_reg;
    logic [PRE_W-1:0] pre_next;
    logic             any_load;
    logic             pre_wrap;
    logic [1:0]       load_vec;
    logic [CNT_W-1:0] ld_val    [2];
    logic [CNT_W-1:0] count_arr [2];
    logic             done_arr  [2];

    // Any load restarts the prescaler so a phase lasts exactly N full ticks.
    always_comb begin
        any_load = Sload_NS | Sload_EW;
        pre_wrap = (pre_reg == PRE_LAST);
        Tick     = Reset_n & ~any_load & pre_wrap;
        pre_next = pre_reg + PRE_W'(1);
        if (any_load || pre_wrap) begin
            pre_next = '0;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            pre_reg <= '0;
        end else begin
            pre_reg <= pre_next;
        end
    end

    // Load table: the value loaded is the duration of the phase that follows State_cnt.
    always_comb begin
        ld_val[0] = NS_GRN;
        ld_val[1] = EW_GRN;
        case (State_cnt)
            S0:      ld_val[0] = YEL;
            S2:      ld_val[1] = YEL;
            default: ;
        endcase
    end

    assign load_vec = {Sload_EW, Sload_NS};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ch
            traffic_down_cnt #(
                .CNT_W  (CNT_W),
                .RST_VAL((gi == 0) ? NS_GRN : EW_GRN)
            ) u_cnt (
                .Clk     (Clk),
                .Reset_n (Reset_n),
                .Load    (load_vec[gi]),
                .Tick    (Tick),
                .Load_val(ld_val[gi]),
                .Count   (count_arr[gi]),
                .Done    (done_arr[gi])
            );

`ifdef TRAFFIC_TIMER_BCD_EN
            logic [7:0] bcd_reg;

            always_ff @(posedge Clk) begin
                if (!Reset_n) begin
                    bcd_reg <= 8'h00;
                end else begin
                    bcd_reg <= bin_to_bcd(32'(count_arr[gi]));
                end
            end
`endif
        end
    endgenerate

    assign Count_NS = count_arr[0];
    assign Count_EW = count_arr[1];
    assign Done_NS  = done_arr[0];
    assign Done_EW  = done_arr[1];

`ifdef TRAFFIC_TIMER_BCD_EN
    assign Bcd_NS = g_ch[0].bcd_reg;
    assign Bcd_EW = g_ch[1].bcd_reg;
`endif

endmodule

// File: tb/tb_traffic_timer.sv
// Directed bench for traffic_timer with short timings (TICK_DIV=4, NS_GRN=5, EW_GRN=4, YEL=2).
// Also checks the BCD outputs when TRAFFIC_TIMER_BCD_EN is defined.
module tb_traffic_timer;

    localparam int TICK_DIV = 4;
    localparam int CNT_W    = 8;
    localparam int NS_GRN   = 5;
    localparam int EW_GRN   = 4;
    localparam int YEL      = 2;

    logic             Clk = 1'b0;
    logic             Reset_n;
    logic             Sload_NS;
    logic             Sload_EW;
    logic [3:0]       State_cnt;
    logic             Done_NS;
    logic             Done_EW;
    logic [CNT_W-1:0] Count_NS;
    logic [CNT_W-1:0] Count_EW;
    logic             Tick;
`ifdef TRAFFIC_TIMER_BCD_EN
    logic [7:0]       Bcd_NS;
    logic [7:0]       Bcd_EW;
`endif

    int vec_cnt = 0;
    int err_cnt = 0;

    traffic_timer #(
        .TICK_DIV   (TICK_DIV),
        .CNT_W      (CNT_W),
        .NS_GRN_TIME(NS_GRN),
        .EW_GRN_TIME(EW_GRN),
        .YEL_TIME   (YEL)
    ) dut (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .Sload_NS (Sload_NS),
        .Sload_EW (Sload_EW),
        .State_cnt(State_cnt),
        .Done_NS  (Done_NS),
        .Done_EW  (Done_EW),
        .Count_NS (Count_NS),
        .Count_EW (Count_EW),
        .Tick     (Tick)
`ifdef TRAFFIC_TIMER_BCD_EN
        ,
        .Bcd_NS   (Bcd_NS),
        .Bcd_EW   (Bcd_EW)
`endif
    );

    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Reset_n   = 1'b0;
        Sload_NS  = 1'b0;
        Sload_EW  = 1'b0;
        State_cnt = 4'b0001;
        repeat (3) step();
        vec_cnt++; if (Count_NS !== 8'd5) begin err_cnt++; $display("FAIL reset_count_ns: got %0d expected 5", Count_NS); end
        vec_cnt++; if (Count_EW !== 8'd4) begin err_cnt++; $display("FAIL reset_count_ew: got %0d expected 4", Count_EW); end
        vec_cnt++; if (Done_NS !== 1'b0) begin err_cnt++; $display("FAIL reset_done_ns: got %b expected 0", Done_NS); end
        vec_cnt++; if (Done_EW !== 1'b0) begin err_cnt++; $display("FAIL reset_done_ew: got %b expected 0", Done_EW); end
        vec_cnt++; if (Tick !== 1'b0) begin err_cnt++; $display("FAIL reset_tick: got %b expected 0", Tick); end
        $display("reset: Count_NS=%0d Count_EW=%0d", Count_NS, Count_EW);
        Reset_n = 1'b1;
    endtask

    task automatic test_ns_yellow();
        State_cnt = 4'b0001;
        Sload_NS  = 1'b1;
        step();
        Sload_NS = 1'b0;
        #1;
        vec_cnt++; if (Count_NS !== 8'd2) begin err_cnt++; $display("FAIL ns_yel_load: got %0d expected 2", Count_NS); end
        for (int c = 0; c < 8; c++) begin
            vec_cnt++; if (Done_NS !== 1'b0) begin err_cnt++; $display("FAIL ns_yel_done_early c=%0d: got %b expected 0", c, Done_NS); end
            vec_cnt++; if (Tick !== ((c % 4) == 3)) begin err_cnt++; $display("FAIL ns_yel_tick c=%0d: got %b expected %b", c, Tick, ((c % 4) == 3)); end
            step();
        end
        vec_cnt++; if (Done_NS !== 1'b1) begin err_cnt++; $display("FAIL ns_yel_done_8: got %b expected 1", Done_NS); end
        $display("ns yellow: Done_NS=%b after 8 cycles", Done_NS);
    endtask

    task automatic test_load_over_tick();
        int n = 0;
        while (Tick !== 1'b1 && n < 10) begin
            step();
            n++;
        end
        vec_cnt++; if (Tick !== 1'b1) begin err_cnt++; $display("FAIL lot_find_tick: got %b expected 1", Tick); end
        State_cnt = 4'b0100;
        Sload_EW  = 1'b1;
        #1;
        vec_cnt++; if (Tick !== 1'b0) begin err_cnt++; $display("FAIL lot_tick_suppressed: got %b expected 0", Tick); end
        step();
        Sload_EW = 1'b0;
        #1;
        vec_cnt++; if (Count_EW !== 8'd2) begin err_cnt++; $display("FAIL lot_count_ew: got %0d expected 2", Count_EW); end
        for (int c = 0; c < 4; c++) begin
            vec_cnt++; if (Tick !== (c == 3)) begin err_cnt++; $display("FAIL lot_pre_restart c=%0d: got %b expected %b", c, Tick, (c == 3)); end
            step();
        end
        $display("load over tick: Count_EW=%0d", Count_EW);
    endtask

    task automatic test_saturation();
        for (int c = 0; c < 20; c++) begin
            vec_cnt++; if (Count_NS !== 8'd0) begin err_cnt++; $display("FAIL sat_count_ns c=%0d: got %0d expected 0", c, Count_NS); end
            vec_cnt++; if (Done_NS !== 1'b1) begin err_cnt++; $display("FAIL sat_done_ns c=%0d: got %b expected 1", c, Done_NS); end
            step();
        end
        $display("saturation: Count_NS=%0d Done_NS=%b", Count_NS, Done_NS);
    endtask

    task automatic test_full_loop();
        int          len_exp [4] = '{20, 8, 16, 8};
        logic [3:0]  st      [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        int          cyc;
        logic        watched;
        State_cnt = 4'b1000;
        Sload_NS  = 1'b1;
        Sload_EW  = 1'b1;
        step();
        Sload_NS  = 1'b0;
        Sload_EW  = 1'b0;
        State_cnt = 4'b0001;
        #1;
        for (int p = 0; p < 4; p++) begin
            cyc = 0;
            watched = (p < 2) ? Done_NS : Done_EW;
            while (watched !== 1'b1 && cyc < 100) begin
                step();
                cyc++;
                watched = (p < 2) ? Done_NS : Done_EW;
            end
            vec_cnt++; if (cyc != len_exp[p]) begin err_cnt++; $display("FAIL loop_len_s%0d: got %0d cycles expected %0d", p, cyc, len_exp[p]); end
            Sload_NS = 1'b1;
            Sload_EW = 1'b1;
            step();
            Sload_NS  = 1'b0;
            Sload_EW  = 1'b0;
            State_cnt = st[(p + 1) % 4];
            #1;
            watched = (p < 2) ? Done_NS : Done_EW;
            vec_cnt++; if (watched !== 1'b0) begin err_cnt++; $display("FAIL loop_pulse_s%0d: got %b expected 0", p, watched); end
            $display("loop phase S%0d: %0d cycles", p, cyc);
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        State_cnt = 4'b0010;
        Sload_EW  = 1'b1;
        step();
        Sload_EW = 1'b0;
        #1;
        while (Count_EW !== 8'd3 && n < 10) begin
            step();
            n++;
        end
        vec_cnt++; if (Count_EW !== 8'd3) begin err_cnt++; $display("FAIL mid_reach3: got %0d expected 3", Count_EW); end
        Reset_n = 1'b0;
        step();
        vec_cnt++; if (Count_EW !== 8'd4) begin err_cnt++; $display("FAIL mid_count_ew: got %0d expected 4", Count_EW); end
        vec_cnt++; if (Count_NS !== 8'd5) begin err_cnt++; $display("FAIL mid_count_ns: got %0d expected 5", Count_NS); end
        vec_cnt++; if (Tick !== 1'b0) begin err_cnt++; $display("FAIL mid_tick: got %b expected 0", Tick); end
`ifdef TRAFFIC_TIMER_BCD_EN
        vec_cnt++; if (Bcd_EW !== 8'h00) begin err_cnt++; $display("FAIL mid_bcd_rst: got %h expected 00", Bcd_EW); end
`endif
        Reset_n = 1'b1;
        #1;
        for (int c = 0; c < 4; c++) begin
            vec_cnt++; if (Tick !== (c == 3)) begin err_cnt++; $display("FAIL mid_pre_zero c=%0d: got %b expected %b", c, Tick, (c == 3)); end
`ifdef TRAFFIC_TIMER_BCD_EN
            if (c == 1) begin
                vec_cnt++; if (Bcd_EW !== 8'h04) begin err_cnt++; $display("FAIL mid_bcd_ew: got %h expected 04", Bcd_EW); end
                vec_cnt++; if (Bcd_NS !== 8'h05) begin err_cnt++; $display("FAIL mid_bcd_ns: got %h expected 05", Bcd_NS); end
            end
`endif
            step();
        end
        $display("reset mid-count: Count_EW=%0d Count_NS=%0d", Count_EW, Count_NS);
    endtask

    initial begin
        test_reset();
        test_ns_yellow();
        test_load_over_tick();
        test_saturation();
        test_full_loop();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
